// File: rtl/unpack_pkg.sv
// rtl/unpack_pkg.sv - constants and types shared by the packet packer and unpack_rx
package unpack_pkg;

    localparam int          DEFAULT_SIZE_BIT_PACK = 1976;
    localparam int          DEFAULT_SIZE_PREAMBLE = 32;
    localparam logic [31:0] DEFAULT_PREAMBLE_DATA = 32'h1ACF_FC1D;
    localparam logic [31:0] DEFAULT_PREAMBLE_IDLE = ~DEFAULT_PREAMBLE_DATA;

    typedef enum logic [1:0] {
        HUNT,
        DATA,
        SKIP,
        CHECK
    } rx_state_t;

    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/unpack_rx_byte_fifo.sv
// rtl/unpack_rx_byte_fifo.sv - first-word-fall-through byte FIFO with flop storage
module byte_fifo
    import unpack_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_wr_en,
    input  fifo_entry_t i_wr_data,
    input  logic        i_rd_en,
    output fifo_entry_t o_rd_data,
    output logic        o_full,
    output logic        o_empty
);

    localparam int                AW       = $clog2(DEPTH);
    localparam logic [AW-1:0]     PTR_ONE  = AW'(1);
    localparam logic [AW:0]       CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW:0]       CNT_FULL = (AW + 1)'(DEPTH);

    fifo_entry_t   mem_q [DEPTH];
    fifo_entry_t   mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          wr_ok;
    logic          rd_ok;

    assign o_full    = (count_q == CNT_FULL);
    assign o_empty   = (count_q == '0);
    assign o_rd_data = mem_q[rd_ptr_q];

    // A read in the same cycle frees the slot, so a write into a full FIFO still lands.
    assign rd_ok = i_rd_en && !o_empty;
    assign wr_ok = i_wr_en && (!o_full || rd_ok);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_ok) begin
            mem_d[wr_ptr_q] = i_wr_data;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end
        if (rd_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/unpack_rx.sv
// rtl/unpack_rx.sv - serial packet receiver: sync hunt, data/idle classification, byte output
module unpack_rx
    import unpack_pkg::*;
#(
    parameter int                           SIZE_BIT_PACK = DEFAULT_SIZE_BIT_PACK,
    parameter int                           SIZE_PREAMBLE = DEFAULT_SIZE_PREAMBLE,
    parameter logic [SIZE_PREAMBLE-1:0]     PREAMBLE_DATA = DEFAULT_PREAMBLE_DATA,
    parameter logic [SIZE_PREAMBLE-1:0]     PREAMBLE_IDLE = DEFAULT_PREAMBLE_IDLE,
    parameter int                           FIFO_DEPTH    = 16
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_data,
    input  logic       i_valid,
    output logic [7:0] o_data,
    output logic       o_last,
    output logic       o_valid,
    input  logic       i_ready,
    output logic       o_lock,
    output logic       o_overflow
);

    localparam int          SIZE_PAYLOAD = SIZE_BIT_PACK - SIZE_PREAMBLE;
    localparam logic [10:0] PAYLOAD_END  = 11'(SIZE_PAYLOAD - 1);
    localparam logic [10:0] PREAMBLE_END = 11'(SIZE_PREAMBLE - 1);
    localparam logic [7:0]  LAST_BYTE    = 8'(SIZE_PAYLOAD / 8 - 1);

    rx_state_t                state_q, state_d;
    logic [SIZE_PREAMBLE-1:0] sr_q, sr_d;
    logic [10:0]              bit_cnt_q, bit_cnt_d;
    logic [7:0]               byte_cnt_q, byte_cnt_d;
    logic                     push_q, push_d;
    fifo_entry_t              push_entry_q, push_entry_d;
    logic                     overflow_q, overflow_d;

    logic [SIZE_PREAMBLE-1:0] cand;
    logic                     fifo_rd;
    logic                     fifo_full;
    logic                     fifo_empty;
    fifo_entry_t              fifo_head;

    assign cand       = {sr_q[SIZE_PREAMBLE-2:0], i_data};
    assign fifo_rd    = o_valid && i_ready;
    assign o_valid    = !fifo_empty;
    assign o_data     = fifo_head.data;
    assign o_last     = fifo_head.last;
    assign o_lock     = (state_q != HUNT);
    assign o_overflow = overflow_q;

    always_comb begin
        state_d      = state_q;
        sr_d         = sr_q;
        bit_cnt_d    = bit_cnt_q;
        byte_cnt_d   = byte_cnt_q;
        push_d       = 1'b0;
        push_entry_d = push_entry_q;
        overflow_d   = push_q && fifo_full && !fifo_rd;
        if (i_valid) begin
            sr_d = cand;
            case (state_q)
                HUNT: begin
                    if (cand == PREAMBLE_DATA) begin
                        state_d    = DATA;
                        bit_cnt_d  = '0;
                        byte_cnt_d = '0;
                    end else if (cand == PREAMBLE_IDLE) begin
                        state_d   = SKIP;
                        bit_cnt_d = '0;
                    end
                end
                DATA: begin
                    // Byte completes on its 8th bit; the FIFO write happens one edge later.
                    if (bit_cnt_q[2:0] == 3'd7) begin
                        push_d            = 1'b1;
                        push_entry_d.data = cand[7:0];
                        push_entry_d.last = (byte_cnt_q == LAST_BYTE);
                        byte_cnt_d        = byte_cnt_q + 8'd1;
                    end
                    if (bit_cnt_q == PAYLOAD_END) begin
                        state_d   = CHECK;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 11'd1;
                    end
                end
                SKIP: begin
                    if (bit_cnt_q == PAYLOAD_END) begin
                        state_d   = CHECK;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 11'd1;
                    end
                end
                CHECK: begin
                    if (bit_cnt_q == PREAMBLE_END) begin
                        bit_cnt_d  = '0;
                        byte_cnt_d = '0;
                        if (cand == PREAMBLE_DATA) begin
                            state_d = DATA;
                        end else if (cand == PREAMBLE_IDLE) begin
                            state_d = SKIP;
                        end else begin
                            state_d = HUNT;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 11'd1;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q      <= HUNT;
            sr_q         <= '0;
            bit_cnt_q    <= '0;
            byte_cnt_q   <= '0;
            push_q       <= 1'b0;
            push_entry_q <= '0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            sr_q         <= sr_d;
            bit_cnt_q    <= bit_cnt_d;
            byte_cnt_q   <= byte_cnt_d;
            push_q       <= push_d;
            push_entry_q <= push_entry_d;
            overflow_q   <= overflow_d;
        end
    end

    byte_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_byte_fifo (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_wr_en  (push_q),
        .i_wr_data(push_entry_q),
        .i_rd_en  (fifo_rd),
        .o_rd_data(fifo_head),
        .o_full   (fifo_full),
        .o_empty  (fifo_empty)
    );

endmodule
